// File: rtl/traffic_pkg.sv
// Shared phase encoding and lamp codes for the parameterised traffic controller.
// Each approach head is a {red,yellow,green} triple.
package traffic_pkg;

   typedef enum logic [1:0] {
      GREEN  = 2'd0,
      YELLOW = 2'd1,
      ALLRED = 2'd2,
      EMG    = 2'd3
   } phase_e;

   localparam logic [2:0] LT_RED = 3'b100;
   localparam logic [2:0] LT_YEL = 3'b010;
   localparam logic [2:0] LT_GRN = 3'b001;

   // Only the owning approach ever shows anything other than red.
   function automatic logic [2:0] head_code(input phase_e ph, input logic owner);
      logic [2:0] code;
      code = LT_RED;
      if (owner) begin
         case (ph)
            GREEN, EMG: code = LT_GRN;
            YELLOW:     code = LT_YEL;
            default:    code = LT_RED;
         endcase
      end
      return code;
   endfunction

endpackage

// File: rtl/rr_next_dir.sv
// Round-robin search for the next approach with demand, starting just after cur_dir.
// When no other approach is asking, next_dir falls back to cur_dir and any_other is low.
module rr_next_dir #(
   parameter int NUM_DIR = 4
) (
   input  logic [NUM_DIR-1:0]         demand,
   input  logic [$clog2(NUM_DIR)-1:0] cur_dir,
   output logic [$clog2(NUM_DIR)-1:0] next_dir,
   output logic                       any_other
);

   localparam int DW = $clog2(NUM_DIR);

   always_comb begin
      int idx;
      next_dir  = cur_dir;
      any_other = 1'b0;
      idx       = 0;
      for (int k = 1; k < NUM_DIR; k++) begin
         idx = (int'(cur_dir) + k) % NUM_DIR;
         if (!any_other && demand[idx]) begin
            next_dir  = DW'(idx);
            any_other = 1'b1;
         end
      end
   end

endmodule

// File: rtl/traffic_ctrl_param.sv
// Parameterised N-approach traffic controller with round-robin demand service and
// emergency pre-emption. All outputs come straight from flops.
module traffic_ctrl_param
   import traffic_pkg::*;
#(
   parameter int NUM_DIR    = 4,
   parameter int GREEN_CYC  = 8,
   parameter int YELLOW_CYC = 3,
   parameter int ALLRED_CYC = 2,
   parameter int CNT_W      = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [NUM_DIR-1:0]         demand,
   input  logic                       emg_req,
   input  logic [$clog2(NUM_DIR)-1:0] emg_dir,
   output logic [3*NUM_DIR-1:0]       lights,
   output logic [$clog2(NUM_DIR)-1:0] cur_dir,
   output logic [1:0]                 phase,
   output logic                       busy_emg
);

   localparam int DW = $clog2(NUM_DIR);
   localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GREEN_CYC - 1);
   localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(YELLOW_CYC - 1);
   localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ALLRED_CYC - 1);

   phase_e            state, state_nxt;
   logic [CNT_W-1:0]  timer, timer_nxt;
   logic [DW-1:0]     dir_nxt;
   logic [DW-1:0]     next_dir, nd_nxt;
   logic              nd_valid, ndv_nxt;
   logic              emg_pend, pend_nxt;
   logic [DW-1:0]     rr_dir;
   logic              any_other;

   rr_next_dir #(.NUM_DIR(NUM_DIR)) u_rr (
      .demand    (demand),
      .cur_dir   (cur_dir),
      .next_dir  (rr_dir),
      .any_other (any_other)
   );

   function automatic logic [3*NUM_DIR-1:0] build_lights(input phase_e ph, input logic [DW-1:0] dir);
      logic [3*NUM_DIR-1:0] lit;
      lit = '0;
      for (int i = 0; i < NUM_DIR; i++)
         lit[3*i +: 3] = head_code(ph, DW'(i) == dir);
      return lit;
   endfunction

   // Next-state logic. next_dir is latched when leaving GREEN (or EMG) and is
   // only bypassed for the very first GREEN after reset, when nothing was latched.
   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      dir_nxt   = cur_dir;
      nd_nxt    = next_dir;
      ndv_nxt   = nd_valid;
      pend_nxt  = emg_pend;
      if (en) begin
         case (state)
            GREEN: begin
               if (emg_req && emg_dir == cur_dir) begin
                  state_nxt = EMG;
               end else if (emg_req) begin
                  state_nxt = YELLOW;
                  pend_nxt  = 1'b1;
               end else if (timer == G_LAST) begin
                  if (any_other) begin
                     state_nxt = YELLOW;
                     nd_nxt    = rr_dir;
                     ndv_nxt   = 1'b1;
                  end
               end else begin
                  timer_nxt = timer + CNT_W'(1);
               end
            end
            YELLOW: begin
               if (emg_req)
                  pend_nxt = 1'b1;
               if (timer == Y_LAST)
                  state_nxt = ALLRED;
               else
                  timer_nxt = timer + CNT_W'(1);
            end
            ALLRED: begin
               if (emg_req)
                  pend_nxt = 1'b1;
               if (timer == A_LAST) begin
                  if (pend_nxt) begin
                     state_nxt = EMG;
                     dir_nxt   = emg_dir;
                     pend_nxt  = 1'b0;
                  end else begin
                     state_nxt = GREEN;
                     dir_nxt   = nd_valid ? next_dir : rr_dir;
                  end
               end else begin
                  timer_nxt = timer + CNT_W'(1);
               end
            end
            EMG: begin
               if (!emg_req) begin
                  state_nxt = YELLOW;
                  nd_nxt    = rr_dir;
                  ndv_nxt   = 1'b1;
               end
            end
            default: state_nxt = ALLRED;
         endcase
         if (state_nxt != state)
            timer_nxt = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ALLRED;
         timer    <= '0;
         cur_dir  <= DW'(NUM_DIR - 1);
         next_dir <= '0;
         nd_valid <= 1'b0;
         emg_pend <= 1'b0;
         lights   <= {NUM_DIR{LT_RED}};
         busy_emg <= 1'b0;
      end else begin
         state    <= state_nxt;
         timer    <= timer_nxt;
         cur_dir  <= dir_nxt;
         next_dir <= nd_nxt;
         nd_valid <= ndv_nxt;
         emg_pend <= pend_nxt;
         lights   <= build_lights(state_nxt, dir_nxt);
         busy_emg <= (state_nxt == EMG);
      end
   end

   assign phase = state;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Directed self-checking bench for traffic_ctrl_param at default parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_traffic_ctrl_param;

   logic        clk;
   logic        rst;
   logic        en;
   logic [3:0]  demand;
   logic        emg_req;
   logic [1:0]  emg_dir;
   logic [11:0] lights;
   logic [1:0]  cur_dir;
   logic [1:0]  phase;
   logic        busy_emg;

   int passed = 0;
   int total  = 0;

   localparam logic [11:0] ALL_RED = 12'h924;

   traffic_ctrl_param dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .demand   (demand),
      .emg_req  (emg_req),
      .emg_dir  (emg_dir),
      .lights   (lights),
      .cur_dir  (cur_dir),
      .phase    (phase),
      .busy_emg (busy_emg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] head(input int dir, input logic [2:0] code);
      logic [11:0] l;
      l = ALL_RED;
      l[3*dir +: 3] = code;
      return l;
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic applyStimulus(input logic e, input logic [3:0] d, input logic er,
                                input logic [1:0] ed, input int ncyc);
      en      = e;
      demand  = d;
      emg_req = er;
      emg_dir = ed;
      repeat (ncyc) @(negedge clk);
   endtask

   task automatic doReset(input logic [3:0] d);
      rst = 1'b1;
      applyStimulus(1'b1, d, 1'b0, 2'd0, 2);
      rst = 1'b0;
   endtask

   initial begin
      logic side_ok;
      rst = 1'b1;
      applyStimulus(1'b1, 4'b1111, 1'b0, 2'd0, 3);
      checkOutput("rst_lights", 16'(lights), 16'(ALL_RED));
      checkOutput("rst_phase", 16'(phase), 16'd2);
      checkOutput("rst_busy", 16'(busy_emg), 16'd0);
      checkOutput("rst_dir", 16'(cur_dir), 16'd3);
      rst = 1'b0;

      // Full rotation with every approach asking
      applyStimulus(1'b1, 4'b1111, 1'b0, 2'd0, 1);
      checkOutput("boot_allred", 16'(phase), 16'd2);
      applyStimulus(1'b1, 4'b1111, 1'b0, 2'd0, 1);
      checkOutput("green0_start", 16'(lights), 16'(head(0, 3'b001)));
      checkOutput("green0_phase", 16'(phase), 16'd0);
      applyStimulus(1'b1, 4'b1111, 1'b0, 2'd0, 7);
      checkOutput("green0_last", 16'(lights), 16'(head(0, 3'b001)));
      applyStimulus(1'b1, 4'b1111, 1'b0, 2'd0, 1);
      checkOutput("yellow0_start", 16'(lights), 16'(head(0, 3'b010)));
      applyStimulus(1'b1, 4'b1111, 1'b0, 2'd0, 2);
      checkOutput("yellow0_last", 16'(phase), 16'd1);
      applyStimulus(1'b1, 4'b1111, 1'b0, 2'd0, 1);
      checkOutput("allred_start", 16'(lights), 16'(ALL_RED));
      applyStimulus(1'b1, 4'b1111, 1'b0, 2'd0, 1);
      checkOutput("allred_last", 16'(phase), 16'd2);
      applyStimulus(1'b1, 4'b1111, 1'b0, 2'd0, 1);
      checkOutput("green1_start", 16'(lights), 16'(head(1, 3'b001)));
      checkOutput("green1_dir", 16'(cur_dir), 16'd1);
      applyStimulus(1'b1, 4'b1111, 1'b0, 2'd0, 38);
      checkOutput("cycle52_allred", 16'(phase), 16'd2);
      applyStimulus(1'b1, 4'b1111, 1'b0, 2'd0, 1);
      checkOutput("cycle52_green0", 16'(lights), 16'(head(0, 3'b001)));
      checkOutput("cycle52_dir", 16'(cur_dir), 16'd0);

      // Enable freeze stretches green to 8+5 cycles
      applyStimulus(1'b1, 4'b1111, 1'b0, 2'd0, 2);
      applyStimulus(1'b0, 4'b1111, 1'b0, 2'd0, 5);
      checkOutput("freeze_lights", 16'(lights), 16'(head(0, 3'b001)));
      checkOutput("freeze_phase", 16'(phase), 16'd0);
      applyStimulus(1'b1, 4'b1111, 1'b0, 2'd0, 5);
      checkOutput("freeze_green13", 16'(lights), 16'(head(0, 3'b001)));
      applyStimulus(1'b1, 4'b1111, 1'b0, 2'd0, 1);
      checkOutput("freeze_yellow", 16'(lights), 16'(head(0, 3'b010)));

      // Asynchronous reset mid-yellow
      applyStimulus(1'b1, 4'b1111, 1'b0, 2'd0, 1);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_rst_lights", 16'(lights), 16'(ALL_RED));
      checkOutput("async_rst_phase", 16'(phase), 16'd2);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b1, 4'b1111, 1'b0, 2'd0, 1);
      checkOutput("post_rst_allred", 16'(phase), 16'd2);
      applyStimulus(1'b1, 4'b1111, 1'b0, 2'd0, 1);
      checkOutput("post_rst_green0", 16'(lights), 16'(head(0, 3'b001)));

      // Pre-emption toward approach 2 while approach 0 is green
      applyStimulus(1'b1, 4'b1111, 1'b0, 2'd0, 2);
      applyStimulus(1'b1, 4'b1111, 1'b1, 2'd2, 1);
      checkOutput("emg_yellow0", 16'(lights), 16'(head(0, 3'b010)));
      checkOutput("emg_yellow_busy", 16'(busy_emg), 16'd0);
      applyStimulus(1'b1, 4'b1111, 1'b1, 2'd2, 3);
      checkOutput("emg_allred", 16'(lights), 16'(ALL_RED));
      applyStimulus(1'b1, 4'b1111, 1'b1, 2'd2, 2);
      checkOutput("emg_green2", 16'(lights), 16'(head(2, 3'b001)));
      checkOutput("emg_busy", 16'(busy_emg), 16'd1);
      checkOutput("emg_phase", 16'(phase), 16'd3);
      applyStimulus(1'b1, 4'b1111, 1'b1, 2'd1, 3);
      checkOutput("emg_dir_ignored", 16'(cur_dir), 16'd2);
      checkOutput("emg_dir_lights", 16'(lights), 16'(head(2, 3'b001)));
      applyStimulus(1'b1, 4'b1111, 1'b0, 2'd1, 1);
      checkOutput("emg_rel_yellow2", 16'(lights), 16'(head(2, 3'b010)));
      checkOutput("emg_rel_busy", 16'(busy_emg), 16'd0);
      // Demand change mid-yellow must not move the latched successor
      applyStimulus(1'b1, 4'b0001, 1'b0, 2'd1, 3);
      checkOutput("emg_rel_allred", 16'(phase), 16'd2);
      applyStimulus(1'b1, 4'b0001, 1'b0, 2'd1, 2);
      checkOutput("resume_green3", 16'(lights), 16'(head(3, 3'b001)));
      checkOutput("resume_dir3", 16'(cur_dir), 16'd3);

      // Single demand: approach 2 holds green indefinitely
      doReset(4'b0100);
      applyStimulus(1'b1, 4'b0100, 1'b0, 2'd0, 2);
      checkOutput("only2_green", 16'(lights), 16'(head(2, 3'b001)));
      applyStimulus(1'b1, 4'b0100, 1'b0, 2'd0, 20);
      checkOutput("only2_hold", 16'(lights), 16'(head(2, 3'b001)));
      checkOutput("only2_phase", 16'(phase), 16'd0);
      // Pre-emption for the approach already green goes straight to EMG
      applyStimulus(1'b1, 4'b0100, 1'b1, 2'd2, 1);
      checkOutput("direct_emg_phase", 16'(phase), 16'd3);
      checkOutput("direct_emg_busy", 16'(busy_emg), 16'd1);
      applyStimulus(1'b1, 4'b0100, 1'b0, 2'd2, 1);
      checkOutput("direct_rel_yellow", 16'(lights), 16'(head(2, 3'b010)));

      // Demand on 0 and 3 only: service alternates 0,3,0
      doReset(4'b1001);
      applyStimulus(1'b1, 4'b1001, 1'b0, 2'd0, 2);
      checkOutput("alt_green0", 16'(lights), 16'(head(0, 3'b001)));
      side_ok = 1'b1;
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         if (lights[8:3] !== 6'b100100) side_ok = 1'b0;
      end
      checkOutput("alt_green3", 16'(lights), 16'(head(3, 3'b001)));
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         if (lights[8:3] !== 6'b100100) side_ok = 1'b0;
      end
      checkOutput("alt_green0_again", 16'(lights), 16'(head(0, 3'b001)));
      checkOutput("alt_1_2_red", 16'(side_ok), 16'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
